resposta_esp: RTL and testbench
===============================

# resposta_esp

Board-side responder for the FPGA game link: it plays the ESP end of the protocol the game core drives. It starts a game, captures each target square the core publishes with `salvaNova`, and runs the turn timer from `decresceT` pulses, raising `fimT` at zero. It forwards the player's detected square as `jogadaFileira`/`jogadaColuna` with an `iniciar` strobe. It sits between the board-sensor scanner and the game core, or in a bench as a stand-in for the ESP.

## Interface
- `TEMPO_INICIAL`, default 30: timer load value in ticks, loaded on every accepted target.
- `LARGURA_T`, default 8: timer width in bits.
- `PULSO_INICIAR`, default 2: `iniciar` high time in cycles, ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: active-low, synchronous.
- `comecar` in 1: one-cycle start request from the board button.
- `linhaGerada` in 3: target row from the game core.
- `colunaGerada` in 3: target column from the game core.
- `salvaNova` in 1: target-valid strobe from the game core.
- `decresceT` in 1: one-cycle timer tick from the game core.
- `casaLinha` in 3: row of the square reported by the sensor scanner.
- `casaColuna` in 3: column of the square reported by the sensor scanner.
- `casaValida` in 1: one-cycle sensor event strobe.
- `jogadaFileira` out 3: registered played row.
- `jogadaColuna` out 3: registered played column.
- `iniciar` out 1: start/move strobe to the game core.
- `fimT` out 1: level, timer expired.
- `alvoLinha` out 3: latched target row.
- `alvoColuna` out 3: latched target column.
- `alvoValido` out 1: a target is held.
- `tempo` out LARGURA_T: remaining ticks.
- `db_estado` out 4: state code.

## Operation
States and codes:
- OCIOSO (0)
- PULSA_INI (1)
- ESPERA_ALVO (2)
- AGUARDA_JOGADA (3)
- PREPARA (4)
- PULSA (5)
- FIM_TEMPO (6)

Transitions:
- OCIOSO: `comecar` → PULSA_INI. All other inputs are ignored.
- PULSA_INI: `iniciar`=1 for PULSO_INICIAR cycles with `jogadaFileira`/`jogadaColuna` = 0, then → ESPERA_ALVO.
- ESPERA_ALVO: `salvaNova` latches `alvoLinha`/`alvoColuna`, sets `alvoValido`=1, loads `tempo`=TEMPO_INICIAL, clears `fimT`, then → AGUARDA_JOGADA.
- AGUARDA_JOGADA, evaluated in this priority:
  1. `casaValida`: latch `casaLinha`/`casaColuna` into `jogadaFileira`/`jogadaColuna`, → PREPARA.
  2. `salvaNova`: reload target and `tempo`, stay.
  3. `decresceT`: `tempo` − 1. If the result is 0, set `fimT`=1 and → FIM_TEMPO.
- PREPARA: one setup cycle with jogada outputs stable and `iniciar`=0, → PULSA.
- PULSA: `iniciar`=1 for PULSO_INICIAR cycles, then clear `alvoValido`.
  - If a target is pending, → AGUARDA_JOGADA with the pending target loaded and the timer reloaded.
  - Otherwise → ESPERA_ALVO.
- FIM_TEMPO: `fimT` held at 1.
  - `salvaNova` is handled as in ESPERA_ALVO: `fimT` clears and the state goes to AGUARDA_JOGADA.
  - `comecar` → PULSA_INI with `fimT` cleared.
  - `casaValida` and `decresceT` are ignored.
- Pending target: a `salvaNova` during PREPARA, PULSA or PULSA_INI is stored in a one-deep pending register. A later strobe overwrites it (last wins).

Rules:
- `tempo` saturates at 0 and never wraps. A `decresceT` while `tempo`=0 has no effect.
- `decresceT` outside AGUARDA_JOGADA is ignored.
- `comecar` outside OCIOSO and FIM_TEMPO is ignored.
- Jogada outputs hold their last value until the next capture; PULSA_INI zeroes them.
- `reset`=0 at a clock edge, mid-operation or not:
  - state → OCIOSO;
  - all outputs 0, `tempo`=0, pending register cleared;
  - any in-progress `iniciar` pulse is truncated on that edge.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `salvaNova` sampled at edge t → `alvoValido` and the alvo outputs are valid and `tempo`=TEMPO_INICIAL from t+1.
- `casaValida` sampled at edge t:
  - jogada outputs valid from t+1;
  - `iniciar` high from t+2 to t+1+PULSO_INICIAR;
  - next state entered at t+2+PULSO_INICIAR.
- `decresceT` at t → `tempo` updated at t+1. On the tick that reaches 0, `fimT`=1 at t+1, the same cycle `tempo` reads 0.
- `comecar` at t → `iniciar` high from t+1 for PULSO_INICIAR cycles.
- Minimum spacing between accepted moves: PULSO_INICIAR+2 cycles.

## Test plan
- **Reset.** Reset low for 2 cycles mid-PULSA → all outputs 0, `db_estado`=0, `iniciar` drops on the reset edge.
- **Start and first target.** `comecar` → `iniciar`=1 for 2 cycles with jogada=0/0, `db_estado`=2. Then `salvaNova` with row 5, col 3 → alvo=5/3, `alvoValido`=1, `tempo`=30.
- **Move.** In AGUARDA_JOGADA, `casaValida` with 5/3 → jogada=5/3 one cycle later, `iniciar` high exactly 2 cycles after a 1-cycle gap, then `db_estado`=2 and `alvoValido`=0.
- **Timeout.** TEMPO_INICIAL=3 and three `decresceT` pulses → `fimT`=1 with `tempo`=0. A 4th pulse leaves `tempo` at 0. A later `salvaNova` clears `fimT` and reloads `tempo`=3.
- **Simultaneous events.** `casaValida` and a final `decresceT` in the same cycle → move captured, `fimT` stays 0, `tempo` unchanged.
- **Pending target.** `salvaNova` with 2/7 during PULSA → after the pulse, `db_estado`=3 directly, alvo=2/7, `tempo` reloaded.

Source files
------------

// File: rtl/resposta_esp.sv
// ESP-side responder for the game link. It starts a game, holds the current target,
// runs the turn timer and forwards detected moves to the game core as timed strobes.
module resposta_esp #(
   parameter int unsigned TEMPO_INICIAL = 30,
   parameter int unsigned LARGURA_T     = 8,
   parameter int unsigned PULSO_INICIAR = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 comecar,
   input  logic [2:0]           linhaGerada,
   input  logic [2:0]           colunaGerada,
   input  logic                 salvaNova,
   input  logic                 decresceT,
   input  logic [2:0]           casaLinha,
   input  logic [2:0]           casaColuna,
   input  logic                 casaValida,
   output logic [2:0]           jogadaFileira,
   output logic [2:0]           jogadaColuna,
   output logic                 iniciar,
   output logic                 fimT,
   output logic [2:0]           alvoLinha,
   output logic [2:0]           alvoColuna,
   output logic                 alvoValido,
   output logic [LARGURA_T-1:0] tempo,
   output logic [3:0]           db_estado
);

   localparam int unsigned         CW          = $clog2(PULSO_INICIAR + 1);
   localparam logic [CW-1:0]       PULSO_FIM   = CW'(PULSO_INICIAR);
   localparam logic [LARGURA_T-1:0] TEMPO_CARGA = LARGURA_T'(TEMPO_INICIAL);

   typedef enum logic [2:0] {
      Ocioso        = 3'd0,
      PulsaIni      = 3'd1,
      EsperaAlvo    = 3'd2,
      AguardaJogada = 3'd3,
      Prepara       = 3'd4,
      Pulsa         = 3'd5,
      FimTempo      = 3'd6
   } estado_t;

   estado_t       estado;
   logic [CW-1:0] cont;
   logic          pend_valido;
   logic [2:0]    pend_linha;
   logic [2:0]    pend_coluna;

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado        <= Ocioso;
         cont          <= '0;
         pend_valido   <= 1'b0;
         pend_linha    <= '0;
         pend_coluna   <= '0;
         jogadaFileira <= '0;
         jogadaColuna  <= '0;
         iniciar       <= 1'b0;
         fimT          <= 1'b0;
         alvoLinha     <= '0;
         alvoColuna    <= '0;
         alvoValido    <= 1'b0;
         tempo         <= '0;
      end else begin
         unique case (estado)
            Ocioso: begin
               if (comecar) begin
                  estado        <= PulsaIni;
                  iniciar       <= 1'b1;
                  cont          <= CW'(1);
                  jogadaFileira <= '0;
                  jogadaColuna  <= '0;
               end
            end

            PulsaIni, Pulsa: begin
               if (cont == PULSO_FIM) begin
                  iniciar     <= 1'b0;
                  pend_valido <= 1'b0;
                  if (estado == Pulsa) alvoValido <= 1'b0;
                  // A strobe on the exit edge is simply the newest pending target.
                  if (salvaNova) begin
                     alvoLinha  <= linhaGerada;
                     alvoColuna <= colunaGerada;
                     alvoValido <= 1'b1;
                     tempo      <= TEMPO_CARGA;
                     fimT       <= 1'b0;
                     estado     <= AguardaJogada;
                  end else if (pend_valido) begin
                     alvoLinha  <= pend_linha;
                     alvoColuna <= pend_coluna;
                     alvoValido <= 1'b1;
                     tempo      <= TEMPO_CARGA;
                     fimT       <= 1'b0;
                     estado     <= AguardaJogada;
                  end else begin
                     estado <= EsperaAlvo;
                  end
               end else begin
                  cont <= cont + CW'(1);
                  if (salvaNova) begin
                     pend_valido <= 1'b1;
                     pend_linha  <= linhaGerada;
                     pend_coluna <= colunaGerada;
                  end
               end
            end

            EsperaAlvo: begin
               if (salvaNova) begin
                  alvoLinha  <= linhaGerada;
                  alvoColuna <= colunaGerada;
                  alvoValido <= 1'b1;
                  tempo      <= TEMPO_CARGA;
                  fimT       <= 1'b0;
                  estado     <= AguardaJogada;
               end
            end

            AguardaJogada: begin
               if (casaValida) begin
                  jogadaFileira <= casaLinha;
                  jogadaColuna  <= casaColuna;
                  estado        <= Prepara;
               end else if (salvaNova) begin
                  alvoLinha  <= linhaGerada;
                  alvoColuna <= colunaGerada;
                  alvoValido <= 1'b1;
                  tempo      <= TEMPO_CARGA;
               end else if (decresceT && tempo != '0) begin
                  tempo <= tempo - LARGURA_T'(1);
                  if (tempo == LARGURA_T'(1)) begin
                     fimT   <= 1'b1;
                     estado <= FimTempo;
                  end
               end
            end

            Prepara: begin
               iniciar <= 1'b1;
               cont    <= CW'(1);
               estado  <= Pulsa;
               if (salvaNova) begin
                  pend_valido <= 1'b1;
                  pend_linha  <= linhaGerada;
                  pend_coluna <= colunaGerada;
               end
            end

            FimTempo: begin
               // Restart takes precedence over a late target.
               if (comecar) begin
                  estado        <= PulsaIni;
                  iniciar       <= 1'b1;
                  cont          <= CW'(1);
                  jogadaFileira <= '0;
                  jogadaColuna  <= '0;
                  fimT          <= 1'b0;
                  alvoValido    <= 1'b0;
               end else if (salvaNova) begin
                  alvoLinha  <= linhaGerada;
                  alvoColuna <= colunaGerada;
                  alvoValido <= 1'b1;
                  tempo      <= TEMPO_CARGA;
                  fimT       <= 1'b0;
                  estado     <= AguardaJogada;
               end
            end

            default: estado <= Ocioso;
         endcase
      end
   end

   assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_resposta_esp.sv
// Scoreboard bench for resposta_esp: two instances (timer loads 30 and 3) share stimulus and are
// compared every cycle against a rule-level model of the responder.
module tb_resposta_esp;

   localparam int P = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0, comecar = 1'b0, salvaNova = 1'b0, decresceT = 1'b0, casaValida = 1'b0;
   logic [2:0] linhaGerada = '0, colunaGerada = '0, casaLinha = '0, casaColuna = '0;

   logic [2:0] jf_a, jc_a, al_a, ac_a, jf_b, jc_b, al_b, ac_b;
   logic       ini_a, fim_a, av_a, ini_b, fim_b, av_b;
   logic [7:0] tempo_a, tempo_b;
   logic [3:0] est_a, est_b;

   resposta_esp #(.TEMPO_INICIAL(30), .LARGURA_T(8), .PULSO_INICIAR(P)) dut_a (
      .clock(clk), .reset(reset), .comecar(comecar), .linhaGerada(linhaGerada),
      .colunaGerada(colunaGerada), .salvaNova(salvaNova), .decresceT(decresceT),
      .casaLinha(casaLinha), .casaColuna(casaColuna), .casaValida(casaValida),
      .jogadaFileira(jf_a), .jogadaColuna(jc_a), .iniciar(ini_a), .fimT(fim_a),
      .alvoLinha(al_a), .alvoColuna(ac_a), .alvoValido(av_a), .tempo(tempo_a), .db_estado(est_a)
   );

   resposta_esp #(.TEMPO_INICIAL(3), .LARGURA_T(8), .PULSO_INICIAR(P)) dut_b (
      .clock(clk), .reset(reset), .comecar(comecar), .linhaGerada(linhaGerada),
      .colunaGerada(colunaGerada), .salvaNova(salvaNova), .decresceT(decresceT),
      .casaLinha(casaLinha), .casaColuna(casaColuna), .casaValida(casaValida),
      .jogadaFileira(jf_b), .jogadaColuna(jc_b), .iniciar(ini_b), .fimT(fim_b),
      .alvoLinha(al_b), .alvoColuna(ac_b), .alvoValido(av_b), .tempo(tempo_b), .db_estado(est_b)
   );

   typedef struct {
      int         mode;
      int         left;
      logic [2:0] jf, jc, al, ac, pl, pc;
      logic       ini, fim, av, pend;
      int         tempo;
   } mdl_t;

   mdl_t        ma, mb;
   logic [26:0] q_a[$], q_b[$];
   int          checks = 0;
   int          failures = 0;
   int          cycle = 0;

   function automatic mdl_t mreset();
      mdl_t n;
      n.mode = 0; n.left = 0; n.tempo = 0;
      n.jf = '0; n.jc = '0; n.al = '0; n.ac = '0; n.pl = '0; n.pc = '0;
      n.ini = 1'b0; n.fim = 1'b0; n.av = 1'b0; n.pend = 1'b0;
      return n;
   endfunction

   function automatic mdl_t carrega(input mdl_t m, input logic [2:0] l, input logic [2:0] c,
                                    input int t0);
      mdl_t n = m;
      n.al = l; n.ac = c; n.av = 1'b1; n.tempo = t0; n.fim = 1'b0;
      return n;
   endfunction

   function automatic mdl_t inicia(input mdl_t m);
      mdl_t n = m;
      n.mode = 1; n.ini = 1'b1; n.jf = '0; n.jc = '0; n.left = P;
      return n;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input logic r, input logic com, input logic sal,
                                  input logic dec, input logic cv, input logic [2:0] lg,
                                  input logic [2:0] cg, input logic [2:0] cl,
                                  input logic [2:0] cc, input int t0);
      mdl_t n = m;
      if (!r) return mreset();
      case (m.mode)
         0: if (com) n = inicia(n);
         1, 5: begin
            if (sal) begin n.pend = 1'b1; n.pl = lg; n.pc = cg; end
            n.left = m.left - 1;
            if (n.left == 0) begin
               n.ini = 1'b0;
               if (m.mode == 5) n.av = 1'b0;
               if (n.pend) begin
                  n = carrega(n, n.pl, n.pc, t0);
                  n.pend = 1'b0;
                  n.mode = 3;
               end else n.mode = 2;
            end
         end
         2: if (sal) begin n = carrega(n, lg, cg, t0); n.mode = 3; end
         3: begin
            if (cv) begin n.jf = cl; n.jc = cc; n.mode = 4; end
            else if (sal) n = carrega(n, lg, cg, t0);
            else if (dec && n.tempo > 0) begin
               n.tempo = n.tempo - 1;
               if (n.tempo == 0) begin n.fim = 1'b1; n.mode = 6; end
            end
         end
         4: begin
            if (sal) begin n.pend = 1'b1; n.pl = lg; n.pc = cg; end
            n.ini = 1'b1; n.left = P; n.mode = 5;
         end
         6: begin
            if (com) begin n = inicia(n); n.fim = 1'b0; n.av = 1'b0; end
            else if (sal) begin n = carrega(n, lg, cg, t0); n.mode = 3; end
         end
         default: n = mreset();
      endcase
      return n;
   endfunction

   function automatic logic [26:0] pack(input mdl_t m);
      return {m.jf, m.jc, m.ini, m.fim, m.al, m.ac, m.av, 8'(m.tempo), 4'(m.mode)};
   endfunction

   task automatic tick(input logic r, input logic c, input logic s, input logic d, input logic v,
                       input logic [2:0] lg, input logic [2:0] cg, input logic [2:0] cl,
                       input logic [2:0] cc);
      @(negedge clk);
      reset = r; comecar = c; salvaNova = s; decresceT = d; casaValida = v;
      linhaGerada = lg; colunaGerada = cg; casaLinha = cl; casaColuna = cc;
      ma = mstep(ma, r, c, s, d, v, lg, cg, cl, cc, 30);
      mb = mstep(mb, r, c, s, d, v, lg, cg, cl, cc, 3);
      q_a.push_back(pack(ma));
      q_b.push_back(pack(mb));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cmp(input string name, input logic [26:0] got, input logic [26:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cycle=%0d got jf=%0d jc=%0d ini=%b fim=%b alvo=%0d/%0d av=%b tempo=%0d est=%0d required jf=%0d jc=%0d ini=%b fim=%b alvo=%0d/%0d av=%b tempo=%0d est=%0d",
                  name, cycle, got[26:24], got[23:21], got[20], got[19], got[18:16], got[15:13],
                  got[12], got[11:4], got[3:0], want[26:24], want[23:21], want[20], want[19],
                  want[18:16], want[15:13], want[12], want[11:4], want[3:0]);
      end
   endtask

   // Monitor: every cycle the DUTs present a state snapshot that must match the queued one.
   initial begin
      logic [26:0] ea, eb;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            cmp("inst_t30", {jf_a, jc_a, ini_a, fim_a, al_a, ac_a, av_a, tempo_a, est_a}, ea);
            cmp("inst_t3",  {jf_b, jc_b, ini_b, fim_b, al_b, ac_b, av_b, tempo_b, est_b}, eb);
         end
      end
   end

   initial begin
      ma = mreset();
      mb = mreset();
      // Reset, start, first target 5/3.
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      tick(1, 0, 1, 0, 0, 3'd5, 3'd3, 0, 0);
      idle(2);
      // Move 5/3.
      tick(1, 0, 0, 0, 1, 0, 0, 3'd5, 3'd3);
      idle(5);
      // Timeout on the short-timer instance, extra tick, then reload.
      tick(1, 0, 1, 0, 0, 3'd1, 3'd1, 0, 0);
      for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle(1);
      tick(1, 0, 1, 0, 0, 3'd4, 3'd4, 0, 0);
      // Move and final tick in the same cycle, then pending target 2/7 during the pulse.
      tick(1, 0, 0, 1, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 1, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 1, 1, 0, 0, 3'd6, 3'd1);
      idle(1);
      tick(1, 0, 1, 0, 0, 3'd2, 3'd7, 0, 0);
      idle(4);
      // Reset for two cycles in the middle of a pulse.
      tick(1, 0, 0, 0, 1, 0, 0, 3'd7, 3'd0);
      idle(2);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         tick(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 19) == 0),
              logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) == 0),
              logic'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      @(posedge clk);
      #2;
      checks++;
      if (q_a.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d required=0 pending snapshots", q_a.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
